// File: rtl/adc_conv_seq.sv
// Conversion sequencer for an 8-bit pipelined parallel ADC: divides aclk into adc_clk,
// discards the pipeline-latency samples after each start, then captures single or continuous samples.
module adc_conv_seq #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              data_rd,
  output logic              adc_clk,
  input  logic [DATA_W-1:0] adc_data,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              data_fresh,
  output logic              overrun
);

  localparam int unsigned LAT_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'((PIPE_LAT == 0) ? 0 : PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] ph_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             cont_lat;

  logic accept;
  logic fall;
  logic capture;
  logic finish;
  logic lat_step;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // stop overrides everything, including a fall landing in the same cycle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    lat_step  = 1'b0;
    fall      = adc_clk && (ph_cnt == '0);
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            accept    = 1'b1;
            state_nxt = (PIPE_LAT == 0) ? RUN : WARMUP;
          end
        end
        WARMUP: begin
          if (fall) begin
            lat_step = 1'b1;
            if (lat_cnt == LAST_LAT) state_nxt = RUN;
          end
        end
        RUN: begin
          if (fall) begin
            capture = 1'b1;
            if (!cont_lat) begin
              finish    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Clock generator: adc_clk rises on the start edge, then toggles every div_lat cycles
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      adc_clk  <= 1'b0;
      ph_cnt   <= '0;
      div_lat  <= '0;
      cont_lat <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      if (accept) begin
        div_lat  <= (clk_div == '0) ? DIV_W'(1) : clk_div;
        ph_cnt   <= (clk_div == '0) ? '0 : clk_div - DIV_W'(1);
        cont_lat <= cont;
        adc_clk  <= 1'b1;
      end else if (state_nxt == IDLE) begin
        adc_clk <= 1'b0;
        ph_cnt  <= '0;
      end else if (ph_cnt == '0) begin
        adc_clk <= ~adc_clk;
        ph_cnt  <= div_lat - DIV_W'(1);
      end else begin
        ph_cnt <= ph_cnt - DIV_W'(1);
      end

      if (accept)        lat_cnt <= '0;
      else if (lat_step) lat_cnt <= lat_cnt + LAT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      sample_valid <= capture;
      done         <= finish;
      if (capture) sample_data <= adc_data;
    end
  end

  // Flags react to the visible sample_valid pulse so a read in that cycle cannot lose the new sample
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_fresh <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sample_valid) begin
        data_fresh <= 1'b1;
        if (data_fresh && !data_rd) overrun <= 1'b1;
      end else if (data_rd) begin
        data_fresh <= 1'b0;
      end
      if (accept) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_conv_seq.sv
// Bench for adc_conv_seq: directed runs with a scoreboard of expected (cycle, data, done) per sample_valid.
module tb_adc_conv_seq;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cont = 1'b0;
  logic [15:0] clk_div = '0;
  logic        data_rd = 1'b0;
  logic        adc_clk;
  logic [7:0]  adc_data = '0;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        data_fresh;
  logic        overrun;

  adc_conv_seq #(.DATA_W(8), .DIV_W(16), .PIPE_LAT(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .cont(cont),
    .clk_div(clk_div), .data_rd(data_rd), .adc_clk(adc_clk), .adc_data(adc_data),
    .sample_data(sample_data), .sample_valid(sample_valid), .busy(busy), .done(done),
    .data_fresh(data_fresh), .overrun(overrun)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int       rel;
    logic [7:0] data;
    logic     done;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_k = 0;
  int fall_cnt = 0;

  // sample presented after the k-th adc_clk rise is vec[k]
  logic [7:0] vec [16] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3, 8'h96, 8'h69, 8'hF0, 8'h0F,
                           8'h81, 8'h7E, 8'h24, 8'hDB, 8'h42, 8'hBD, 8'h18, 8'hE7};

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge adc_clk) begin
    int idx;
    rise_k = rise_k + 1;
    idx = rise_k & 15;
    #1 adc_data = vec[idx];
  end

  always @(negedge adc_clk) fall_cnt = fall_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual %0h required %0h (rel cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  always @(negedge aclk) begin
    if (sample_valid) begin
      if (q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_valid actual data %0h at rel cycle %0d required no valid",
                 sample_data, cyc - t0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", cyc - t0, e.rel);
        chk("valid_data", {24'd0, sample_data}, {24'd0, e.data});
        chk("valid_done", {31'd0, done}, {31'd0, e.done});
        chk("valid_busy", {31'd0, busy}, {31'd0, ~e.done});
      end
    end
  end

  task automatic push(input int rel, input logic [7:0] data, input logic d);
    exp_t e;
    e.rel = rel;
    e.data = data;
    e.done = d;
    q.push_back(e);
  endtask

  task automatic pulse_start(input logic [15:0] div, input logic c);
    @(negedge aclk);
    start = 1'b1;
    cont = c;
    clk_div = div;
    t0 = cyc;
    rise_k = 0;
    fall_cnt = 0;
    @(negedge aclk);
    start = 1'b0;
    cont = ~c;
    clk_div = 16'hFFFF;
  endtask

  task automatic goto_rel(input int r);
    while (cyc - t0 < r) @(negedge aclk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_adc_clk"}, {31'd0, adc_clk}, 0);
    chk({tag, "_sample_data"}, {24'd0, sample_data}, 0);
    chk({tag, "_sample_valid"}, {31'd0, sample_valid}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_data_fresh"}, {31'd0, data_fresh}, 0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 0);
  endtask

  // single conversion: done at (2*3+1)*d+1, adc_clk high/low d cycles each until then
  task automatic run_single(input logic [15:0] div, input int d);
    pulse_start(div, 1'b0);
    push(7 * d + 1, 8'h96, 1'b1);
    for (int r = 1; r <= 7 * d; r++) begin
      goto_rel(r);
      chk("adc_clk_wave", {31'd0, adc_clk}, (((r - 1) / d) % 2 == 0) ? 1 : 0);
      if (r == 7 * d) chk("busy_before_done", {31'd0, busy}, 1);
    end
    goto_rel(7 * d + 1);
    chk("busy_after_done", {31'd0, busy}, 0);
    chk("adc_clk_after_done", {31'd0, adc_clk}, 0);
    chk("fall_count", fall_cnt, 4);
    goto_rel(7 * d + 6);
    chk("adc_clk_idle", {31'd0, adc_clk}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge aclk);
    chk_zero_outputs("reset");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    run_single(16'd4, 4);
    chk("fresh_after_single", {31'd0, data_fresh}, 1);
    chk("overrun_after_single", {31'd0, overrun}, 0);
    run_single(16'd7, 7);
    run_single(16'd1, 1);
    run_single(16'd0, 1);
    chk("overrun_unread_singles", {31'd0, overrun}, 1);

    // start while busy with different div/cont is ignored
    pulse_start(16'd4, 1'b0);
    push(29, 8'h96, 1'b1);
    goto_rel(10);
    start = 1'b1; cont = 1'b1; clk_div = 16'd2;
    goto_rel(11);
    start = 1'b0;
    goto_rel(12);
    chk("busy_start_clk", {31'd0, adc_clk}, 1);
    goto_rel(30);
    chk("busy_start_idle", {31'd0, busy}, 0);

    // start with stop while idle
    @(negedge aclk);
    start = 1'b1; stop = 1'b1; cont = 1'b0; clk_div = 16'd4;
    @(negedge aclk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", {31'd0, busy}, 0);
    repeat (5) @(negedge aclk);
    chk("start_stop_busy_later", {31'd0, busy}, 0);
    chk("start_stop_clk", {31'd0, adc_clk}, 0);

    // continuous div 2, no reads, stop at 20
    data_rd = 1'b1;
    @(negedge aclk);
    data_rd = 1'b0;
    chk("rd_clears_fresh", {31'd0, data_fresh}, 0);
    pulse_start(16'd2, 1'b1);
    push(15, 8'h96, 1'b0);
    push(19, 8'h69, 1'b0);
    chk("start_clears_overrun", {31'd0, overrun}, 0);
    goto_rel(16);
    chk("cont_fresh_1st", {31'd0, data_fresh}, 1);
    chk("cont_overrun_1st", {31'd0, overrun}, 0);
    goto_rel(20);
    chk("cont_overrun_2nd", {31'd0, overrun}, 1);
    stop = 1'b1;
    goto_rel(21);
    stop = 1'b0;
    chk("stop_clk", {31'd0, adc_clk}, 0);
    chk("stop_busy", {31'd0, busy}, 0);
    chk("stop_keeps_overrun", {31'd0, overrun}, 1);
    chk("stop_keeps_data", {24'd0, sample_data}, 8'h69);
    goto_rel(30);

    // continuous with reads coincident with valids; stop coincides with a fall
    data_rd = 1'b1;
    @(negedge aclk);
    data_rd = 1'b0;
    pulse_start(16'd2, 1'b1);
    push(15, 8'h96, 1'b0);
    push(19, 8'h69, 1'b0);
    goto_rel(15);
    data_rd = 1'b1;
    goto_rel(16);
    data_rd = 1'b0;
    chk("rd_coinc_fresh", {31'd0, data_fresh}, 1);
    chk("rd_coinc_overrun", {31'd0, overrun}, 0);
    goto_rel(19);
    data_rd = 1'b1;
    goto_rel(20);
    data_rd = 1'b0;
    chk("rd_coinc2_fresh", {31'd0, data_fresh}, 1);
    chk("rd_coinc2_overrun", {31'd0, overrun}, 0);
    goto_rel(22);
    stop = 1'b1;
    goto_rel(23);
    stop = 1'b0;
    chk("stop_fall_busy", {31'd0, busy}, 0);
    chk("stop_fall_clk", {31'd0, adc_clk}, 0);
    goto_rel(30);
    chk("stop_fall_data", {24'd0, sample_data}, 8'h69);

    // reset mid-WARMUP, then repeat div 4 single
    pulse_start(16'd4, 1'b0);
    goto_rel(6);
    #2 aresetn = 1'b0;
    #1 chk_zero_outputs("midreset");
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    run_single(16'd4, 4);

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_conv_seq.md
# adc_conv_seq

Conversion sequencer between the AXI-Lite ADC register block and the external 8-bit parallel pipelined ADC pins. It generates the divided `adc_clk` and discards the ADC pipeline-latency samples after each start. It captures `adc_data` into a data holding register, in single-shot or continuous mode, and reports `busy`, `done`, `data_fresh` and `overrun` status back to the register block.

## Interface
Parameters:
- `DATA_W`, 8: ADC sample width.
- `DIV_W`, 16: width of the clock-divider value.
- `PIPE_LAT`, 3: ADC pipeline latency in `adc_clk` cycles. This many samples are discarded after each start.

Ports (one clock; reset is asynchronous and active-low):
- `aclk`  in  1: system clock (50 MHz); all logic is on its rising edge.
- `aresetn`  in  1: asynchronous active-low reset.
- `start`  in  1: one-cycle pulse from the CTL start bit.
- `stop`  in  1: one-cycle pulse from the CTL stop bit.
- `cont`  in  1: 1 = continuous mode, 0 = single conversion. Sampled with `start`.
- `clk_div`  in  DIV_W: half-period of `adc_clk` in `aclk` cycles. Sampled with `start`.
- `data_rd`  in  1: one-cycle pulse when the register block reads DATA.
- `adc_clk`  out  1: ADC conversion clock. Driven directly from a flop.
- `adc_data`  in  DATA_W: ADC output bus, synchronous to `adc_clk`.
- `sample_data`  out  DATA_W: last captured sample.
- `sample_valid`  out  1: one-cycle pulse when `sample_data` is updated.
- `busy`  out  1: sequencer is not IDLE.
- `done`  out  1: one-cycle pulse when a single conversion completes.
- `data_fresh`  out  1: an unread sample is held.
- `overrun`  out  1: sticky flag; a sample overwrote an unread sample.

## Operation
- States:
  - IDLE: `adc_clk` = 0.
  - WARMUP: discard falls; counter `lat_cnt` counts up to PIPE_LAT.
  - RUN: capture on every fall.
- Start handling:
  - `start` in IDLE latches `div_lat = (clk_div == 0) ? 1 : clk_div` and latches `cont`.
  - It clears `overrun` and `lat_cnt`.
  - Next state is WARMUP, or RUN directly if PIPE_LAT = 0.
- `start` while busy is ignored. `clk_div` and `cont` changes while busy have no effect.
- Clock generation:
  - Down-counter `ph_cnt` is loaded with `div_lat-1`.
  - When `ph_cnt` = 0, `adc_clk` toggles and `ph_cnt` reloads.
  - Result: `adc_clk` is high for `div_lat` cycles, then low for `div_lat` cycles.
- Fall event: the edge at which `adc_clk` goes 1→0.
  - In WARMUP, a fall increments `lat_cnt`. At PIPE_LAT falls the state moves to RUN (sample not captured).
  - In RUN, a fall captures `adc_data` into `sample_data` on that same `aclk` edge and pulses `sample_valid`.
- Single mode, first RUN capture:
  - `done` pulses together with `sample_valid`.
  - State goes to IDLE, `adc_clk` stays 0, `busy` deasserts in the same cycle as `done`.
- Continuous mode: captures every `2*div_lat` cycles until `stop`.
- `stop`, in any non-IDLE state:
  - State goes to IDLE next edge and `adc_clk` is forced 0.
  - No `sample_valid` or `done` is produced, even if a fall coincides.
  - `sample_data` and the flags are retained.
- `start` and `stop` in the same cycle: `stop` wins; stays IDLE when idle.
- `data_fresh` and `overrun`:
  - `data_fresh` is set by `sample_valid` and cleared by `data_rd`.
  - `sample_valid` with `data_fresh` = 1 and no `data_rd` in the same cycle sets `overrun`.
  - `sample_valid` and `data_rd` in the same cycle: `data_fresh` stays 1 and `overrun` is unchanged.
- Reset values: all outputs 0, state IDLE, counters 0.
- `aresetn` low mid-operation: immediate return to reset values; `adc_clk` drops asynchronously.

## Timing
- The `start` pulse is in cycle 0.
- `adc_clk` is high in cycles 1..`div_lat`. The k-th fall makes `adc_clk` low from cycle `(2k-1)*div_lat+1`.
- `sample_valid` is high in cycle `(2k-1)*div_lat+1` for k > PIPE_LAT. The captured value is `adc_data` present at the edge closing cycle `(2k-1)*div_lat`.
- Single conversion: `done` in cycle `(2*PIPE_LAT+1)*div_lat+1`. That is cycle 29 for div 4, cycle 50 for div 7, cycle 8 for div 1 (PIPE_LAT = 3).
- No combinational path from any input to any output.
- Divider arithmetic is unsigned. `div_lat` maximum is 2^DIV_W-1 with no wrap, because the counter reload happens before underflow.

## Test plan
- div=4, single, PIPE_LAT=3, random `adc_data` per `adc_clk`: exactly four `adc_clk` falls. `sample_valid` and `done` both in cycle 29. `sample_data` equals the bench-modelled 4th sample. `busy` is 0 from cycle 29.
- div=7 then div=1, single: `done` at cycles 50 and 8 respectively. `adc_clk` high/low widths are 7/7 and 1/1. div=0 behaves exactly like div=1.
- div=2, continuous: `sample_valid` at cycles 15, 19, 23, … (period 4). Pulsing `stop` at cycle 20 gives `adc_clk` = 0 and `busy` = 0 from cycle 21, with no further valids.
- Continuous without `data_rd`: `overrun` set at the second valid. `data_rd` coincident with a valid leaves `data_fresh` = 1 and `overrun` = 0. The next `start` clears `overrun`.
- `start` and `stop` in the same cycle while idle, and `start` while busy: no state change, and the in-flight conversion timing is unchanged.
- `aresetn` asserted mid-WARMUP: all outputs read 0 immediately. After release, a new `start` reproduces the div=4 single timing exactly.
